key_entry_acc: RTL and testbench

Clocked, parametrised keypad entry accumulator for the calculator front end. It consumes one decoded 4-bit key code per accepted press and maintains a DIGITS-deep decimal entry as a BCD shift register. A sequential BCD-to-binary converter turns that entry into a binary operand. Operator keys flush the entry as an operand/opcode pair to the arithmetic unit. It sits between the keypad scanner/debouncer and the calculator core.

---
 rtl/key_entry_pkg.sv | 31 +++
 rtl/bcd_to_bin_seq.sv | 61 ++++++
 rtl/key_entry_acc.sv | 142 ++++++++++++++
 tb/tb_key_entry_acc.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_entry_pkg.sv
// Shared key codes, FSM state type and width helper for the keypad entry accumulator.
package key_entry_pkg;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_OP_ADD    = 4'hA;
    localparam logic [3:0] KEY_OP_SUB    = 4'hB;
    localparam logic [3:0] KEY_OP_MUL    = 4'hC;
    localparam logic [3:0] KEY_OP_DIV    = 4'hD;
    localparam logic [3:0] KEY_OP_EQ     = 4'hE;
    localparam logic [3:0] KEY_BKSP      = 4'hF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_e;

    // Bits needed to hold 10^digits - 1.
    function automatic int min_out_w(input int digits);
        longint unsigned m;
        int w;
        m = 1;
        for (int i = 0; i < digits; i++) m = m * 10;
        m = m - 1;
        w = 0;
        for (int i = 0; i < 64; i++) begin
            if ((m >> i) != 0) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter: one digit per cycle, MSD first,
// acc = acc*8 + acc*2 + digit. done is high on the final cycle with result valid.
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic                done,
    output logic [OUT_W-1:0]    result
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    logic          busy_q, busy_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [BW-1:0] sh_q, sh_d;
    logic [OUT_W-1:0] acc_q, acc_d, acc_nx;
    logic [3:0]    digit;

    always_comb begin
        digit  = sh_q[BW-1 -: 4];
        acc_nx = (acc_q << 3) + (acc_q << 1) + OUT_W'(digit);
        done   = busy_q && (idx_q == LAST);
        result = acc_nx;
        busy_d = busy_q;
        idx_d  = idx_q;
        sh_d   = sh_q;
        acc_d  = acc_q;
        if (start) begin
            busy_d = 1'b1;
            idx_d  = '0;
            sh_d   = bcd_in;
            acc_d  = '0;
        end else if (busy_q) begin
            acc_d = acc_nx;
            sh_d  = sh_q << 4;
            idx_d = idx_q + CW'(1);
            if (done) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            idx_q  <= '0;
            sh_q   <= '0;
            acc_q  <= '0;
        end else begin
            busy_q <= busy_d;
            idx_q  <= idx_d;
            sh_q   <= sh_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/key_entry_acc.sv
// Keypad entry accumulator: BCD entry register, operator capture and conversion FSM.
// Define KEY_ENTRY_BKSP_EN to make key 0xF a backspace; otherwise it is an operator.
module key_entry_acc
    import key_entry_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         key_valid,
    input  logic [3:0]                   key_code,
    output logic                         key_ready,
    output logic                         key_lost,
    output logic [4*DIGITS-1:0]          bcd,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         entry_full,
    output logic [OUT_W-1:0]             value,
    output logic                         op_valid,
    output logic [3:0]                   op_code,
    output logic [OUT_W-1:0]             op_operand
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] FULL = CW'(DIGITS);

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $fatal(1, "key_entry_acc: DIGITS must be 1..8");
    end
    if (OUT_W < min_out_w(DIGITS)) begin : g_bad_width
        $fatal(1, "key_entry_acc: OUT_W too narrow for DIGITS");
    end

    state_e          state_q, state_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0] value_q, value_d;
    logic            op_valid_q, op_valid_d;
    logic [3:0]      op_code_q, op_code_d;
    logic [OUT_W-1:0] op_operand_q, op_operand_d;
    logic            key_lost_q, key_lost_d;
    logic            conv_start, conv_done;
    logic [OUT_W-1:0] conv_result;

    always_comb begin
        state_d      = state_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        value_d      = value_q;
        op_valid_d   = 1'b0;
        op_code_d    = op_code_q;
        op_operand_d = op_operand_q;
        key_lost_d   = 1'b0;
        conv_start   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    if (key_code <= KEY_DIGIT_MAX) begin
                        // Leading zeros and digits past a full entry are dropped silently.
                        if (cnt_q != FULL && !(key_code == 4'h0 && cnt_q == '0)) begin
                            bcd_d      = (bcd_q << 4) | BW'(key_code);
                            cnt_d      = cnt_q + CW'(1);
                            conv_start = 1'b1;
                            state_d    = ST_CONV;
                        end
`ifdef KEY_ENTRY_BKSP_EN
                    end else if (key_code == KEY_BKSP) begin
                        if (cnt_q != '0) begin
                            bcd_d      = bcd_q >> 4;
                            cnt_d      = cnt_q - CW'(1);
                            conv_start = 1'b1;
                            state_d    = ST_CONV;
                        end
`endif
                    end else begin
                        op_valid_d   = 1'b1;
                        op_code_d    = key_code;
                        op_operand_d = value_q;
                        bcd_d        = '0;
                        cnt_d        = '0;
                        value_d      = '0;
                    end
                end
            end
            ST_CONV: begin
                key_lost_d = key_valid;
                if (conv_done) begin
                    value_d = conv_result;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bcd_q        <= '0;
            cnt_q        <= '0;
            value_q      <= '0;
            op_valid_q   <= 1'b0;
            op_code_q    <= '0;
            op_operand_q <= '0;
            key_lost_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            value_q      <= value_d;
            op_valid_q   <= op_valid_d;
            op_code_q    <= op_code_d;
            op_operand_q <= op_operand_d;
            key_lost_q   <= key_lost_d;
        end
    end

    // The converter snapshots the post-update entry at start.
    bcd_to_bin_seq #(
        .DIGITS(DIGITS),
        .OUT_W (OUT_W)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bcd_in(bcd_d),
        .done  (conv_done),
        .result(conv_result)
    );

    assign key_ready   = (state_q == ST_IDLE);
    assign key_lost    = key_lost_q;
    assign bcd         = bcd_q;
    assign digit_count = cnt_q;
    assign entry_full  = (cnt_q == FULL);
    assign value       = value_q;
    assign op_valid    = op_valid_q;
    assign op_code     = op_code_q;
    assign op_operand  = op_operand_q;

endmodule

// File: tb/tb_key_entry_acc.sv
// Scoreboard bench for key_entry_acc: a digit-list reference model queues
// expected events; a negedge monitor pops and compares them as the DUT emits them.
module tb_key_entry_acc;

    localparam int DIGITS = 4;
    localparam int OUT_W  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic        key_lost;
    logic [15:0] bcd;
    logic [2:0]  digit_count;
    logic        entry_full;
    logic [15:0] value;
    logic        op_valid;
    logic [3:0]  op_code;
    logic [15:0] op_operand;

    key_entry_acc #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .key_lost   (key_lost),
        .bcd        (bcd),
        .digit_count(digit_count),
        .entry_full (entry_full),
        .value      (value),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .op_operand (op_operand)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          val;
        logic [15:0] bcd;
        int          cnt;
    } conv_t;

    typedef struct {
        int         cyc;
        logic [3:0] code;
        int         operand;
    } op_t;

    conv_t convq[$];
    op_t   opq[$];
    int    lostq[$];
    int    dq[$];
    int    busy_end = -1;
    int    errors = 0;
    int    checks = 0;
    bit    ready_prev = 1'b1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int mval();
        int v = 0;
        foreach (dq[i]) v = v * 10 + dq[i];
        return v;
    endfunction

    function automatic logic [15:0] mbcd();
        logic [15:0] b = '0;
        foreach (dq[i]) b = (b << 4) | 16'(dq[i]);
        return b;
    endfunction

    function automatic void push_conv();
        conv_t c;
        c.cyc = cyc + DIGITS + 1;
        c.val = mval();
        c.bcd = mbcd();
        c.cnt = dq.size();
        convq.push_back(c);
        busy_end = cyc + DIGITS;
    endfunction

    function automatic void model_key(input logic [3:0] code);
        op_t o;
        if (cyc <= busy_end) begin
            lostq.push_back(cyc + 1);
        end else if (code <= 4'd9) begin
            if (!(code == 4'd0 && dq.size() == 0) && dq.size() < DIGITS) begin
                dq.push_back(int'(code));
                push_conv();
            end
`ifdef KEY_ENTRY_BKSP_EN
        end else if (code == 4'hF) begin
            if (dq.size() > 0) begin
                dq.delete(dq.size() - 1);
                push_conv();
            end
`endif
        end else begin
            o.cyc     = cyc + 1;
            o.code    = code;
            o.operand = mval();
            opq.push_back(o);
            dq.delete();
        end
    endfunction

    function automatic void model_reset();
        dq.delete();
        convq.delete();
        opq.delete();
        lostq.delete();
        busy_end = -1;
    endfunction

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        model_key(code);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc <= busy_end) idle();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, key_ready, 1);
        chk({tag, "_lost"}, key_lost, 0);
        chk({tag, "_bcd"}, bcd, 0);
        chk({tag, "_count"}, digit_count, 0);
        chk({tag, "_full"}, entry_full, 0);
        chk({tag, "_value"}, value, 0);
        chk({tag, "_opv"}, op_valid, 0);
        chk({tag, "_opcode"}, op_code, 0);
        chk({tag, "_operand"}, op_operand, 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            ready_prev = 1'b1;
        end else begin
            if (key_lost) begin
                chk("lost_expected", lostq.size() > 0, 1);
                if (lostq.size() > 0) chk("lost_cycle", cyc, lostq.pop_front());
            end
            if (op_valid) begin
                chk("op_expected", opq.size() > 0, 1);
                if (opq.size() > 0) begin
                    op_t o;
                    o = opq.pop_front();
                    chk("op_cycle", cyc, o.cyc);
                    chk("op_code", op_code, o.code);
                    chk("op_operand", op_operand, o.operand);
                    chk("op_clr_value", value, 0);
                    chk("op_clr_bcd", bcd, 0);
                    chk("op_clr_count", digit_count, 0);
                end
            end
            if (!key_ready && ready_prev) begin
                chk("conv_start_expected", convq.size() > 0, 1);
                if (convq.size() > 0) chk("conv_start_cycle", cyc + DIGITS, convq[0].cyc);
            end
            if (key_ready && !ready_prev) begin
                chk("conv_done_expected", convq.size() > 0, 1);
                if (convq.size() > 0) begin
                    conv_t c;
                    c = convq.pop_front();
                    chk("conv_cycle", cyc, c.cyc);
                    chk("conv_value", value, c.val);
                    chk("conv_bcd", bcd, c.bcd);
                    chk("conv_count", digit_count, c.cnt);
                    chk("conv_full", entry_full, c.cnt == DIGITS);
                end
            end
            ready_prev = key_ready;
        end
    end

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        #1;
        chk_reset_vals("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();

        press(4'd1); wait_idle();
        press(4'd2); wait_idle();
        press(4'd3); wait_idle();
        chk("dir_123_value", value, 123);
        chk("dir_123_bcd", bcd, 16'h0123);
        chk("dir_123_count", digit_count, 3);

        press(4'd4); wait_idle();
        press(4'd5); idle(); idle();
        chk("dir_full_value", value, 1234);
        chk("dir_full_flag", entry_full, 1);
        chk("dir_full_ready", key_ready, 1);
        press(4'hE);

        press(4'd4); wait_idle();
        press(4'd2); wait_idle();
        press(4'hA);
        chk("dir_op_valid", op_valid, 1);
        chk("dir_op_code", op_code, 4'hA);
        chk("dir_op_operand", op_operand, 42);
        chk("dir_op_value", value, 0);
        idle();
        chk("dir_op_pulse", op_valid, 0);
        chk("dir_op_hold", op_operand, 42);

        press(4'd1); wait_idle();
        press(4'd2); wait_idle();
        press(4'd3); wait_idle();
        press(4'hF); wait_idle();
`ifdef KEY_ENTRY_BKSP_EN
        chk("dir_bksp_value", value, 12);
        chk("dir_bksp_count", digit_count, 2);
        press(4'hF); wait_idle();
        press(4'hF); wait_idle();
        press(4'hF); wait_idle();
        chk("dir_bksp_zero", value, 0);
`else
        chk("dir_f_opcode", op_code, 4'hF);
        chk("dir_f_operand", op_operand, 123);
`endif

        press(4'd8); wait_idle();
        press(4'd1);
        press(4'd7);
        chk("dir_lost", key_lost, 1);
        chk("dir_lost_value", value, 8);
        wait_idle();
        chk("dir_after_lost", value, 81);
        press(4'hB);

        press(4'd3); idle(); idle();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midconv");
        model_reset();
        idle(); idle();
        rst_n = 1'b1;
        idle();
        chk("post_reset_ready", key_ready, 1);

        press(4'd0); idle();
        press(4'd0); idle();
        press(4'd5); wait_idle();
        chk("dir_lead0_count", digit_count, 1);
        chk("dir_lead0_value", value, 5);
        press(4'hC);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 55) press(4'($urandom_range(0, 9)));
                else if (r < 85) press(4'($urandom_range(10, 14)));
                else press(4'hF);
            end else begin
                idle();
            end
        end

        repeat (DIGITS + 4) idle();
        chk("drain_conv", convq.size(), 0);
        chk("drain_op", opq.size(), 0);
        chk("drain_lost", lostq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
